// File: rtl/stmn_p2s.sv
// stmn_p2s: STM-N byte-to-serial converter with frame-synchronous 1+x^6+x^7 scrambler and B1 BIP-8
// Ports:
//   clk155  - serial bit clock (only clock)
//   rst155  - synchronous active-low reset
//   en      - run enable; low freezes every register and blanks sdo/sof/ldreq
//   scr_dis - scrambler bypass, taken per byte when ldreq samples it
//   pdi     - parallel byte, sampled on the clock where ldreq=1
//   ldreq   - byte-load strobe, one in every 8 enabled cycles
//   row/col - frame position of the byte being requested
//   sdo     - serial data, MSB first
//   sof     - marks the MSB of row 0, col 0 on sdo
//   b1dat   - BIP-8 of the last completed frame
//   b1vld   - one-cycle strobe when b1dat updates
module stmn_p2s #(
  parameter int NSTS = 1,
  parameter int SOH_COLS = 9
) (
  input  logic        clk155,
  input  logic        rst155,
  input  logic        en,
  input  logic        scr_dis,
  input  logic [7:0]  pdi,
  output logic        ldreq,
  output logic [3:0]  row,
  output logic [11:0] col,
  output logic        sdo,
  output logic        sof,
  output logic [7:0]  b1dat,
  output logic        b1vld
);
  localparam logic [11:0] NCOL = 12'(270 * NSTS);
  localparam logic [11:0] NSOH = 12'(SOH_COLS * NSTS);
  logic [2:0]  r_bit;
  logic [3:0]  r_row;
  logic [11:0] r_col;
  logic [7:0]  r_sh, r_acc, r_b1dat;
  logic [6:0]  r_s;
  logic        r_uns, r_dis, r_last, r_sdo, r_sof, r_fin, r_b1vld;
  logic        w_ld, w_row0, w_first, w_uns, w_dis, w_d, w_o, w_lastbit;
  logic [6:0]  w_s;
  logic [7:0]  w_mask;
  // On the load cycle the byte's attributes come straight from pdi/row/col;
  // for its remaining seven bits they come from the values latched at load.
  always_comb begin
    w_ld      = en && r_bit == 3'd7;
    w_row0    = r_row == 4'd0;
    w_first   = w_ld && w_row0 && r_col == 12'd0;
    w_uns     = w_ld ? (w_row0 && r_col < NSOH) : r_uns;
    w_dis     = w_ld ? scr_dis : r_dis;
    w_s       = (w_ld && w_row0 && r_col == NSOH) ? 7'h7F : r_s;
    w_d       = w_ld ? pdi[7] : r_sh[7];
    w_o       = w_d ^ (w_s[6] & ~w_uns & ~w_dis);
    w_mask    = w_ld ? 8'h80 : 8'h40 >> r_bit;
    w_lastbit = en && r_bit == 3'd6 && r_last;
  end
  // Gating with en blanks the held bit during a pause; it reappears on resume.
  assign ldreq = w_ld;
  assign sdo   = r_sdo & en;
  assign sof   = r_sof & en;
  assign row   = r_row;
  assign col   = r_col;
  assign b1dat = r_b1dat;
  assign b1vld = r_b1vld;
  always_ff @(posedge clk155) begin
    if (!rst155) begin
      r_bit   <= 3'd7;
      r_row   <= 4'd0;
      r_col   <= 12'd0;
      r_s     <= 7'h7F;
      r_acc   <= 8'h00;
      r_sh    <= 8'h00;
      r_uns   <= 1'b0;
      r_dis   <= 1'b0;
      r_last  <= 1'b0;
      r_sdo   <= 1'b0;
      r_sof   <= 1'b0;
      r_fin   <= 1'b0;
      r_b1dat <= 8'h00;
      r_b1vld <= 1'b0;
    end else begin
      // r_fin marks the edge that put the frame's last bit on sdo; B1 is
      // published one edge later, before the next frame's clear can land.
      r_fin   <= w_lastbit;
      r_b1vld <= r_fin;
      if (r_fin) r_b1dat <= r_acc;
      if (en) begin
        r_bit <= r_bit + 3'd1;
        r_sh  <= w_ld ? {pdi[6:0], 1'b0} : {r_sh[6:0], 1'b0};
        r_sdo <= w_o;
        r_sof <= w_first;
        r_acc <= (w_first ? 8'h00 : r_acc) ^ (w_o ? w_mask : 8'h00);
        if (!w_uns) r_s <= {w_s[5:0], w_s[6] ^ w_s[5]};
        if (w_ld) begin
          r_uns  <= w_uns;
          r_dis  <= scr_dis;
          r_last <= r_row == 4'd8 && r_col == NCOL - 12'd1;
          r_col  <= r_col == NCOL - 12'd1 ? 12'd0 : r_col + 12'd1;
          r_row  <= r_col == NCOL - 12'd1 ? (r_row == 4'd8 ? 4'd0 : r_row + 4'd1) : r_row;
        end
      end
    end
  end
endmodule

// File: doc/stmn_p2s.md
STMN_P2S -- requirements
Module: stmn_p2s

Interface
REQ-001 SHALL have parameter NSTS, default 1, meaning STM-N order; legal values 1 and 4; columns per row = 270*NSTS.
REQ-002 SHALL have parameter SOH_COLS, default 9, meaning unscrambled row-0 overhead columns per STS; the unscrambled byte count is SOH_COLS*NSTS.
REQ-003 SHALL have port clk155, input, 1, serial bit clock; the only clock.
REQ-004 SHALL have port rst155, input, 1, synchronous active-low reset.
REQ-005 SHALL have port en, input, 1, run enable; when low, all state holds and sdo is 0.
REQ-006 SHALL have port scr_dis, input, 1, scrambler bypass when high; B1 is still computed on sdo.
REQ-007 SHALL have port pdi, input, 8, parallel byte; sampled on the clock where ldreq=1.
REQ-008 SHALL have port ldreq, output, 1, byte-load strobe; one cycle in every 8 enabled cycles.
REQ-009 SHALL have port row, output, 4, row (0..8) of the byte being requested.
REQ-010 SHALL have port col, output, 12, column (0..270*NSTS-1) of the byte being requested.
REQ-011 SHALL have port sdo, output, 1, serial output, MSB first.
REQ-012 SHALL have port sof, output, 1, high with the first sdo bit of each frame.
REQ-013 SHALL have port b1dat, output, 8, BIP-8 of the completed frame.
REQ-014 SHALL have port b1vld, output, 1, one-cycle strobe when b1dat updates.

Function
REQ-015 SHALL count bit position 0..7 on enabled cycles; ldreq asserts at bit position 7; the sampled pdi is loaded into the shift register and driven at bit position 0 of the next byte (latency: 1 clock from sample to first bit).
REQ-016 SHALL advance row/col once per byte: col wraps 270*NSTS-1 -> 0 with row+1, and row wraps 8 -> 0; row/col on ldreq identify the byte sampled.
REQ-017 SHALL drive sof=1 on the cycle where the bit of (row 0, col 0, MSB) is on sdo.
REQ-018 SHALL implement scrambler 1+x^6+x^7: state s[6:0]; output bit s[6]; next state {s[5:0], s[6]^s[5]}; advances only on scrambled bits.
REQ-019 SHALL preset s to 7'h7F on the first bit of row 0, col SOH_COLS*NSTS; the bytes of row 0, cols 0..SOH_COLS*NSTS-1 SHALL pass unscrambled.
REQ-020 SHALL set sdo = data bit XOR scrambler bit, or data bit when scr_dis=1 or in unscrambled bytes; sdo is registered.
REQ-021 SHALL compute B1 as bit-interleaved even parity of every sdo bit of a frame, with bit k (MSB=7) taken from byte bit k; the accumulator clears at sof.
REQ-022 SHALL latch the accumulator into b1dat and pulse b1vld on the cycle after the last bit (row 8, last col, LSB) leaves sdo.
REQ-023 SHALL hold all counters, the scrambler, the accumulator and the shift register while en=0; the serial stream resumes at the exact bit where it stopped.
REQ-024 SHALL take effect on scr_dis changes only at byte boundaries (sampled with ldreq).

Reset
REQ-025 SHALL, while rst155=0, set: bit counter 7 (so ldreq=1 on the first enabled cycle after reset); row=0, col=0; s=7'h7F; B1 accumulator 0; sdo=0, sof=0, b1dat=8'h00, b1vld=0.
REQ-026 SHALL abandon a partial frame on reset mid-frame, with no b1vld; the first frame after reset starts at row 0, col 0.

Verification
REQ-027 Reset, en=1, pdi=8'h00, scr_dis=0: ldreq on the first cycle; sof 1 cycle later; row-0 SOH bits=0; from row 0, col 9*NSTS, sdo = 1111111000000100000110000101...
REQ-028 scr_dis=1, pdi=8'hA5 constant, NSTS=1: sdo repeats 10100101; after 2430 bytes b1vld=1 and b1dat=8'h00 (even byte count).
REQ-029 NSTS=4, scr_dis=1, pdi=8'h01 at row 0, col 0 only, all other bytes 0: b1dat=8'h01; frame length 77760 clocks between sof pulses.
REQ-030 en toggled low for 5 cycles mid-byte: sdo=0 during the gap; the concatenated stream and b1dat are identical to a run without the gap.
REQ-031 Reset asserted at row 4: no b1vld; the next sof occurs 1 clock after the first ldreq following release, with row=0, col=0.
REQ-032 Random pdi, scr_dis=0, 3 frames: sdo, sof and b1dat match a bit-accurate reference model for each frame.
